// File: rtl/clk_en_pkg.sv
// clk_en_pkg: shared types and defaults for the
// multirate clock-enable scheduler.
package clk_en_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int SAM_DIV_DEF = 4;
    localparam int DEC_DEF     = 4;

endpackage

// File: rtl/mod_counter.sv
// mod_counter: modulo-MOD counter with clear and
// increment; clear together with inc restarts at 1.
module mod_counter #(
    parameter int MOD = 4,
    parameter int W   = $clog2(MOD)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         wrap
);

    assign wrap = inc && (count == W'(MOD - 1));

    // count state: clear has priority, and a clear that
    // coincides with inc counts the current cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? W'(1) : '0;
        end else if (inc) begin
            count <= wrap ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/clk_en_scheduler.sv
// clk_en_scheduler: sample/symbol clock-enable strobes
// with start, prime, run, stop and resync sequencing.
module clk_en_scheduler
    import clk_en_pkg::*;
#(
    parameter int SAM_DIV = SAM_DIV_DEF,
    parameter int DEC     = DEC_DEF,
    parameter int PH_W    = $clog2(DEC)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    input  logic            sync,
    input  logic [PH_W-1:0] sym_phase_sel,
    output logic            sam_clk_en,
    output logic            sym_clk_en,
    output logic [PH_W-1:0] sam_phase,
    output logic            active,
    output logic            aligned
);

    localparam int CLK_W = $clog2(SAM_DIV);

    state_t            state;
    logic [CLK_W-1:0]  cnt_clk;
    logic [PH_W-1:0]   cnt_sam;
    logic              clk_inc;
    logic              clk_clr;
    logic              clk_wrap;
    logic              sam_inc;
    logic              sam_clr;
    logic              sam_wrap;
    logic              abort;
    logic              sync_ok;
    logic              sym_hit;

    // leaving PRIME on run low drops the pending strobe
    assign abort   = (state == PRIME) && !run;
    assign sync_ok = sync && run &&
                     ((state == PRIME) || (state == RUN));

    // the start/resync cycle itself counts as divider tick 0
    assign clk_clr = (state == IDLE) || abort || sync_ok;
    assign clk_inc = (state == IDLE) ? run : !abort;

    assign sam_clr = clk_clr;
    assign sam_inc = clk_wrap && !sam_clr;

    assign sym_hit = clk_wrap &&
                     ((state == RUN) || (state == STOP)) &&
                     (cnt_sam == sym_phase_sel);

    mod_counter #(
        .MOD (SAM_DIV),
        .W   (CLK_W)
    ) u_clk_div (
        .clk   (clk),
        .reset (reset),
        .inc   (clk_inc),
        .clr   (clk_clr),
        .count (cnt_clk),
        .wrap  (clk_wrap)
    );

    mod_counter #(
        .MOD (DEC),
        .W   (PH_W)
    ) u_sam_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (sam_inc),
        .clr   (sam_clr),
        .count (cnt_sam),
        .wrap  (sam_wrap)
    );

    // sequencing FSM with registered strobes and status
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            sam_clk_en <= 1'b0;
            sym_clk_en <= 1'b0;
            sam_phase  <= '0;
            active     <= 1'b0;
            aligned    <= 1'b0;
        end else begin
            sam_clk_en <= clk_wrap;
            sym_clk_en <= sym_hit;
            aligned    <= sync_ok;
            if (clk_wrap) begin
                sam_phase <= cnt_sam;
            end
            unique case (state)
                IDLE: begin
                    if (run) begin
                        state  <= PRIME;
                        active <= 1'b1;
                    end else begin
                        active <= 1'b0;
                    end
                end
                PRIME: begin
                    if (abort) begin
                        state  <= IDLE;
                        active <= 1'b0;
                    end else begin
                        active <= 1'b1;
                        if (sync_ok) begin
                            state <= PRIME;
                        end else if (sam_wrap) begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    active <= 1'b1;
                    if (!run) begin
                        state <= STOP;
                    end else if (sync_ok) begin
                        state <= PRIME;
                    end
                end
                STOP: begin
                    if (run) begin
                        state  <= RUN;
                        active <= 1'b1;
                    end else if (sam_wrap) begin
                        state  <= IDLE;
                        active <= 1'b0;
                    end else begin
                        active <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/clk_en_scheduler.md
# clk_en_scheduler

Generates the single-cycle clock-enable strobes that sequence the multirate receive chain. Drives the sample-rate enable for down-samplers and filters, plus a decimated symbol-rate enable. Provides a start/prime/run/stop sequence and a resynchronisation input. Sits between the top-level control and every `clk_en` input in the datapath.

## Interface
- `SAM_DIV`, 4: clk cycles per sample period; must be ≥2.
- `DEC`, 4: samples per symbol; power of two, ≥2.
- `PH_W`, $clog2(DEC): phase width (derived).
- `clk` in 1: single system clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `run` in 1: level; high requests strobe generation, low requests stop.
- `sync` in 1: pulse; realigns counters to phase 0.
- `sym_phase_sel` in PH_W: sample phase on which `sym_clk_en` fires; sampled every cycle.
- `sam_clk_en` out 1: sample-rate strobe, one cycle wide.
- `sym_clk_en` out 1: symbol-rate strobe, one cycle wide, always coincident with a `sam_clk_en`.
- `sam_phase` out PH_W: index 0..DEC-1 of the current sample within the symbol; valid while `sam_clk_en` is high.
- `active` out 1: high in PRIME, RUN and STOP.
- `aligned` out 1: one-cycle pulse after an accepted `sync`.

## Operation
- **Counters:**
  - `cnt_clk` runs 0..SAM_DIV-1 and wraps.
  - `cnt_sam` runs 0..DEC-1 and advances once per `sam_clk_en`.
  - `sam_phase` equals `cnt_sam`.
- **IDLE:**
  - All strobes are low and the counters are held at 0.
  - `run` sampled high moves to PRIME.
- **PRIME:**
  - `sam_clk_en` runs; `sym_clk_en` is suppressed.
  - After the strobe with `sam_phase`=DEC-1, the block moves to RUN, so DEC samples flush the pipeline.
  - `run` low moves to IDLE immediately and clears the counters.
- **RUN:**
  - `sym_clk_en` = `sam_clk_en` & (`sam_phase`==`sym_phase_sel`).
  - `run` low moves to STOP.
- **STOP:**
  - Strobes continue through the strobe with `sam_phase`=DEC-1, including any `sym_clk_en` due, then the block moves to IDLE.
  - `run` high again in STOP returns to RUN with no gap in the strobes.
- **sync:**
  - Honoured only in PRIME or RUN.
  - Zeroes both counters and enters PRIME.
  - Pulses `aligned` in the next cycle.
  - Ignored in IDLE and STOP.
- **Simultaneous events:**
  - `run` low and `sync` in the same cycle: the stop action wins and `sync` is ignored.
  - `reset` overrides everything.
- **Reset:** all outputs 0, counters 0, state IDLE, effective the cycle after `reset` is sampled, including mid-symbol.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Cycle 0 is the cycle in which `run` is first sampled high in IDLE.
- `active` is high from cycle 1.
- `sam_clk_en` is high in cycles SAM_DIV, 2·SAM_DIV, …, with `sam_phase` = 0, 1, …, DEC-1, 0, …
- The first `sym_clk_en` occurs at sample index DEC + `sym_phase_sel`, i.e. cycle (DEC+`sym_phase_sel`+1)·SAM_DIV.
- After `sync` is accepted in cycle c:
  - `aligned` is high in c+1.
  - The next `sam_clk_en` is in cycle c+SAM_DIV, with `sam_phase`=0.
  - Any strobe scheduled in cycle c is still emitted.
- `sym_phase_sel` changes take effect at the next `sam_clk_en`.

## Structure
- Shared package `clk_en_pkg`: state enum {IDLE, PRIME, RUN, STOP}, defaults `SAM_DIV_DEF`=4 and `DEC_DEF`=4.
- Sub-module `mod_counter`, instantiated twice (clock divider and sample counter):
  - Parameter MOD; inputs `inc`, `clr`; outputs `count` and `wrap`.
  - `wrap` = `inc` & (`count`==MOD-1).
- Top level holds the FSM and registers the output strobes.

## Test plan
- **Start-up:** reset, then `run`=1 at cycle 0 with SAM_DIV=4, DEC=4, `sym_phase_sel`=0.
  - `sam_clk_en` at cycles 4, 8, 12, 16, 20 with `sam_phase` 0, 1, 2, 3, 0.
  - First `sym_clk_en` at cycle 20.
  - `active` from cycle 1.
- **Phase select:** `sym_phase_sel`=2 in RUN.
  - `sym_clk_en` only with `sam_phase`=2, every 16 cycles.
  - Exactly one `sym_clk_en` per 4 `sam_clk_en`.
- **Graceful stop:** `run` falls while `sam_phase`=1 in RUN.
  - Strobes for phases 2 and 3 are still emitted, then IDLE with `active`=0.
  - No further strobes for 100 cycles.
  - `run` re-raised during STOP instead gives an uninterrupted 4-cycle cadence.
- **Resync:** `sync` pulsed mid-symbol in RUN at cycle c.
  - `aligned`=1 at c+1.
  - Next `sam_clk_en` at c+4 with `sam_phase`=0.
  - No `sym_clk_en` until 4 samples later (PRIME).
  - `sync` in IDLE produces no `aligned` pulse.
- **Reset mid-operation:** `reset` asserted between strobes in RUN.
  - All outputs 0 the next cycle; state IDLE.
  - Restart timing identical to the start-up scenario.
- **Parameter sweep:** SAM_DIV=2, DEC=2 and SAM_DIV=7, DEC=8.
  - Strobe spacing, `sam_phase` wrap and first-`sym_clk_en` cycle match the formulas in Timing.
